// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Mini-SRC control unit.
// Sequences fetch (T0-T2) and execute (T3-T6) and Moore-decodes every
// datapath strobe from the current state plus ir[31:27].
// Optional build macro: CU_SINGLE_STEP_EN adds the step input and a STEPWAIT
// state that gates the start of every instruction after the first.
module control_sequencer #(
    parameter int OPCODE_W   = 5,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [31:0]         ir,
    input  logic                mem_done,
`ifdef CU_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                Cout,
    output logic                Yin,
    output logic                Zlowin,
    output logic                Zhighin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                LOin,
    output logic                HIin,
    output logic [OPCODE_W-1:0] opcode,
    output logic                run,
    output logic                illegal_op,
    output logic                bus_err
);

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALTED
`ifdef CU_SINGLE_STEP_EN
        ,
        S_STEPWAIT
`endif
    } state_t;

    // Where a completed (or skipped) instruction goes next.
`ifdef CU_SINGLE_STEP_EN
    localparam state_t S_END = S_STEPWAIT;
`else
    localparam state_t S_END = S_T0;
`endif

    localparam int CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    // Counter value seen during the last permitted T1 cycle.
    localparam logic [CNT_W-1:0] LIMIT_LAST = (WAIT_LIMIT == 0) ? '0 : CNT_W'(WAIT_LIMIT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_bus_err;

    logic [4:0]       w_op;
    logic             w_is_alu3;
    logic             w_is_imm;
    logic             w_is_muldiv;
    logic             w_is_negnot;
    logic             w_is_nop;
    logic             w_is_halt;
    logic             w_is_exec;
    logic             w_timeout;
    logic             w_unused_ir;

    assign w_op        = ir[31:27];
    assign w_unused_ir = ^ir[26:0];

    assign w_is_alu3   = (w_op >= 5'd3)  && (w_op <= 5'd11);
    assign w_is_imm    = (w_op >= 5'd12) && (w_op <= 5'd14);
    assign w_is_muldiv = (w_op == 5'd15) || (w_op == 5'd16);
    assign w_is_negnot = (w_op == 5'd17) || (w_op == 5'd18);
    assign w_is_nop    = (w_op == 5'd26);
    assign w_is_halt   = (w_op == 5'd27);
    assign w_is_exec   = w_is_alu3 | w_is_imm | w_is_muldiv | w_is_negnot;

    // mem_done takes priority over the timeout on the final permitted cycle.
    assign w_timeout = (WAIT_LIMIT != 0) && (r_wait_cnt == LIMIT_LAST) && !mem_done;

    assign bus_err = r_bus_err;

    // State register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) r_state <= S_RST;
        else       r_state <= w_next;
    end

    // T1 wait counter: counts consecutive T1 cycles, zero elsewhere.
    always_ff @(posedge clock or posedge clear) begin
        if (clear)                                 r_wait_cnt <= '0;
        else if (r_state == S_T1 && w_next == S_T1) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        else                                       r_wait_cnt <= '0;
    end

    // Sticky memory-timeout flag, cleared only by reset.
    always_ff @(posedge clock or posedge clear) begin
        if (clear)                             r_bus_err <= 1'b0;
        else if (r_state == S_T1 && w_timeout) r_bus_err <= 1'b1;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST: w_next = S_T0;
            S_T0:  w_next = S_T1;
            S_T1: begin
                if (mem_done)       w_next = S_T2;
                else if (w_timeout) w_next = S_HALTED;
            end
            S_T2:  w_next = S_T3;
            S_T3: begin
                if (w_is_exec)      w_next = S_T4;
                else if (w_is_halt) w_next = S_HALTED;
                else                w_next = S_END;
            end
            S_T4:  w_next = S_T5;
            S_T5:  w_next = w_is_muldiv ? S_T6 : S_END;
            S_T6:  w_next = S_END;
            S_HALTED: w_next = S_HALTED;
`ifdef CU_SINGLE_STEP_EN
            S_STEPWAIT: if (step) w_next = S_T0;
`endif
            default: w_next = S_RST;
        endcase
    end

    // Moore output decode from state and the IR opcode field.
    always_comb begin
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        PCin       = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        Cout       = 1'b0;
        Yin        = 1'b0;
        Zlowin     = 1'b0;
        Zhighin    = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        opcode     = '0;
        run        = 1'b1;
        illegal_op = 1'b0;
        case (r_state)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (w_is_exec) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (!w_is_nop && !w_is_halt) begin
                    illegal_op = 1'b1;
                end
            end
            S_T4: begin
                opcode = ir[31 -: OPCODE_W];
                Zlowin = 1'b1;
                if (w_is_alu3) begin
                    Grc  = 1'b1;
                    Rout = 1'b1;
                end else if (w_is_imm) begin
                    Cout = 1'b1;
                end else if (w_is_negnot) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                end else if (w_is_muldiv) begin
                    Grc     = 1'b1;
                    Rout    = 1'b1;
                    Zhighin = 1'b1;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (w_is_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            S_HALTED: run = 1'b0;
            default: ;
        endcase
    end

endmodule
